sdram_wfifo: RTL and testbench

SDRAM_WFIFO -- requirements
Module: sdram_wfifo

---
 rtl/sdram_wfifo.sv | 93 +++++++++
 tb/tb_sdram_wfifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_wfifo.sv
// Write-data FIFO between the RISC-side write path and the SDRAM data interface.
// Head-of-queue data falls through to sd_wfifo_DQ_in; sticky over/underflow flags.
module sdram_wfifo #(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6
) (
  input  logic                     sdram_clk,
  input  logic                     sdram_rst_n,
  input  logic                     wr_push,
  input  logic [31:0]              wr_data,
  output logic                     wr_full,
  output logic                     wr_afull,
  input  logic                     sd_wfifo_pop,
  output logic                     sd_wfifo_empty,
  output logic [31:0]              sd_wfifo_DQ_in,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf_err,
  output logic                     udf_err,
  input  logic                     err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LVL_FULL  = (PW+1)'(DEPTH);
  localparam logic [PW:0] LVL_AFULL = (PW+1)'(AFULL_LVL);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          empty, full;
  logic          push_ok, pop_ok;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_FULL);

  // A pop frees the slot the same-edge push needs, so push is allowed when full+pop.
  assign pop_ok  = sd_wfifo_pop && !empty;
  assign push_ok = wr_push && (!full || pop_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
    else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
  end

  // Error set takes priority over clear when both land on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_push && full && !pop_ok) ovf_d = 1'b1;
    if (sd_wfifo_pop && empty)      udf_d = 1'b1;
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (push_ok) mem[wptr_q] <= wr_data;
  end

  assign sd_wfifo_empty = empty;
  assign wr_full        = full;
  assign wr_afull       = (level_q >= LVL_AFULL);
  assign level          = level_q;
  assign ovf_err        = ovf_q;
  assign udf_err        = udf_q;
  // Gating by empty keeps stale storage invisible, including straight after reset.
  assign sd_wfifo_DQ_in = empty ? 32'h0 : mem[rptr_q];

endmodule

// File: tb/tb_sdram_wfifo.sv
// Directed bench for sdram_wfifo: reset, fill/overflow, full push+pop,
// underflow with push, streamed wrap-around and mid-operation reset.
module tb_sdram_wfifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_push, sd_pop, err_clr;
  logic [31:0] wr_data;
  logic        wr_full, wr_afull, sd_empty, ovf_err, udf_err;
  logic [31:0] dq;
  logic [3:0]  level;
  logic [8:0]  st;

  int checks = 0;
  int fails  = 0;

  sdram_wfifo #(.DEPTH(8), .AFULL_LVL(6)) dut (
    .sdram_clk(clk), .sdram_rst_n(rst_n),
    .wr_push(wr_push), .wr_data(wr_data),
    .wr_full(wr_full), .wr_afull(wr_afull),
    .sd_wfifo_pop(sd_pop), .sd_wfifo_empty(sd_empty),
    .sd_wfifo_DQ_in(dq), .level(level),
    .ovf_err(ovf_err), .udf_err(udf_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // {empty, full, afull, ovf, udf, level}
  assign st = {sd_empty, wr_full, wr_afull, ovf_err, udf_err, level};

  function automatic logic [8:0] exp_st(input bit e, input bit f, input bit af,
                                        input bit ov, input bit ud, input int lv);
    return {e, f, af, ov, ud, 4'(lv)};
  endfunction

  // One clock with the given inputs; returns 1ns after the edge with inputs idle.
  task automatic step(input bit push, input logic [31:0] d, input bit pop, input bit clr);
    wr_push = push; wr_data = d; sd_pop = pop; err_clr = clr;
    @(posedge clk); #1;
    wr_push = 1'b0; sd_pop = 1'b0; err_clr = 1'b0; wr_data = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_push = 0; sd_pop = 0; err_clr = 0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (st !== exp_st(1, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL reset_status got=%b exp=%b", st, exp_st(1, 0, 0, 0, 0, 0));
    end
    checks++;
    if (dq !== 32'h0) begin fails++; $display("FAIL reset_dq got=%h exp=0", dq); end
    rst_n = 1'b1;
  endtask

  task automatic test_first_push;
    step(1, 32'h1111_2222, 0, 0);
    checks++;
    if (st !== exp_st(0, 0, 0, 0, 0, 1)) begin
      fails++; $display("FAIL first_push_status got=%b exp=%b", st, exp_st(0, 0, 0, 0, 0, 1));
    end
    checks++;
    if (dq !== 32'h1111_2222) begin fails++; $display("FAIL first_push_dq got=%h exp=11112222", dq); end
    step(0, 0, 1, 0);
    checks++;
    if (st !== exp_st(1, 0, 0, 0, 0, 0) || dq !== 32'h0) begin
      fails++; $display("FAIL drain_empty got=%b dq=%h exp=%b dq=0", st, dq, exp_st(1, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_fill_overflow;
    for (int i = 0; i < 8; i++) begin
      step(1, 32'(i), 0, 0);
      checks++;
      if (st !== exp_st(0, i == 7, i >= 5, 0, 0, i + 1)) begin
        fails++; $display("FAIL fill_%0d got=%b exp=%b", i, st, exp_st(0, i == 7, i >= 5, 0, 0, i + 1));
      end
    end
    step(1, 32'h99, 0, 0);
    checks++;
    if (st !== exp_st(0, 1, 1, 1, 0, 8) || dq !== 32'h0) begin
      fails++; $display("FAIL overflow got=%b dq=%h exp=%b dq=0", st, dq, exp_st(0, 1, 1, 1, 0, 8));
    end
  endtask

  task automatic test_full_push_pop;
    step(0, 0, 0, 1);
    checks++;
    if (ovf_err !== 1'b0) begin fails++; $display("FAIL ovf_clear got=%b exp=0", ovf_err); end
    checks++;
    if (dq !== 32'h0) begin fails++; $display("FAIL full_head got=%h exp=0", dq); end
    step(1, 32'hA, 1, 0);
    checks++;
    if (st !== exp_st(0, 1, 1, 0, 0, 8)) begin
      fails++; $display("FAIL full_push_pop got=%b exp=%b", st, exp_st(0, 1, 1, 0, 0, 8));
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (dq !== ((i == 8) ? 32'hA : 32'(i))) begin
        fails++; $display("FAIL full_drain_%0d got=%h exp=%h", i, dq, (i == 8) ? 32'hA : 32'(i));
      end
      step(0, 0, 1, 0);
    end
    checks++;
    if (st !== exp_st(1, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL full_drain_end got=%b exp=%b", st, exp_st(1, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_underflow;
    step(1, 32'h5, 1, 0);
    checks++;
    if (st !== exp_st(0, 0, 0, 0, 1, 1) || dq !== 32'h5) begin
      fails++; $display("FAIL udf_push got=%b dq=%h exp=%b dq=5", st, dq, exp_st(0, 0, 0, 0, 1, 1));
    end
    step(0, 0, 0, 1);
    checks++;
    if (udf_err !== 1'b0) begin fails++; $display("FAIL udf_clear got=%b exp=0", udf_err); end
    step(0, 0, 1, 0);
    // pop on empty together with clear: the new error must stick
    step(0, 0, 1, 1);
    checks++;
    if (st !== exp_st(1, 0, 0, 0, 1, 0)) begin
      fails++; $display("FAIL udf_set_wins got=%b exp=%b", st, exp_st(1, 0, 0, 0, 1, 0));
    end
    step(0, 0, 0, 1);
    checks++;
    if (udf_err !== 1'b0) begin fails++; $display("FAIL udf_clear2 got=%b exp=0", udf_err); end
  endtask

  task automatic test_stream;
    logic [31:0] q[$];
    int pushed = 0, popped = 0, cyc = 0;
    bit dp, du;
    bit bad = 0;
    while ((pushed < 20 || q.size() > 0) && cyc < 200) begin
      dp = (cyc % 2 == 1) && (q.size() > 0);
      du = (pushed < 20) && (cyc % 4 != 3) && (q.size() < 8 || dp);
      if (dp) begin
        checks++;
        if (dq !== q[0]) begin
          fails++; bad = 1; $display("FAIL stream_pop_%0d got=%h exp=%h", popped, dq, q[0]);
        end
      end
      step(du, 32'hC000_0000 + 32'(pushed), dp, 0);
      if (dp) begin void'(q.pop_front()); popped++; end
      if (du) begin q.push_back(32'hC000_0000 + 32'(pushed)); pushed++; end
      if (level !== 4'(q.size()) || level > 4'd8) begin
        checks++; fails++; bad = 1;
        $display("FAIL stream_level cyc=%0d got=%0d exp=%0d", cyc, level, q.size());
      end
      cyc++;
    end
    checks++;
    if (popped != 20 || pushed != 20) begin
      fails++; $display("FAIL stream_count popped=%0d pushed=%0d exp=20", popped, pushed);
    end
    checks++;
    if (st !== exp_st(1, 0, 0, 0, 0, 0) || bad) begin
      fails++; $display("FAIL stream_end got=%b exp=%b", st, exp_st(1, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) step(1, 32'hD0 + 32'(i), 0, 0);
    checks++;
    if (level !== 4'd5) begin fails++; $display("FAIL mid_level_pre got=%0d exp=5", level); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (st !== exp_st(1, 0, 0, 0, 0, 0) || dq !== 32'h0) begin
      fails++; $display("FAIL async_reset got=%b dq=%h exp=%b dq=0", st, dq, exp_st(1, 0, 0, 0, 0, 0));
    end
    @(posedge clk); #1 rst_n = 1'b1;
    step(1, 32'h77, 0, 0);
    checks++;
    if (dq !== 32'h77 || level !== 4'd1) begin
      fails++; $display("FAIL post_reset_head got=%h lvl=%0d exp=77 lvl=1", dq, level);
    end
    step(0, 0, 1, 0);
    checks++;
    if (st !== exp_st(1, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL post_reset_drain got=%b exp=%b", st, exp_st(1, 0, 0, 0, 0, 0));
    end
  endtask

  initial begin
    test_reset;
    test_first_push;
    test_fill_overflow;
    test_full_push_pop;
    test_underflow;
    test_stream;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
